rf_alu_seq: RTL and testbench

- Multi-cycle control sequencer for the RF_ALU datapath (register file, ALU, write-back muxes).
- Fetches 16-bit instructions over a req/ack instruction port, decodes them and drives the RF_ALU control and address inputs.
- Handles data-memory req/ack for loads and stores, maintains the PC, and counts retired instructions.

---
 rtl/rf_alu_seq.sv | 216 +++++++++++++++++++++
 tb/tb_rf_alu_seq.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_alu_seq.sv
// rf_alu_seq: multi-cycle fetch/decode/mem/write-back sequencer
// driving the RF_ALU datapath controls.
module rf_alu_seq #(
  parameter logic [15:0] PC_RESET = 16'h0000,
  parameter int          CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             start,
  output logic             imem_req,
  output logic [15:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [15:0]      imem_rdata,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [15:0]      dmem_addr,
  output logic [15:0]      dmem_wdata,
  input  logic             dmem_ack,
  input  logic [15:0]      Result,
  input  logic [15:0]      RD2,
  input  logic             C,
  input  logic             V,
  input  logic             N,
  input  logic             Z,
  output logic [1:0]       ALUctrl,
  output logic             ALUsrc,
  output logic [2:0]       RdAddr,
  output logic [2:0]       RnAddr,
  output logic [2:0]       RmAddr,
  output logic [7:0]       imm8,
  output logic [4:0]       imm5,
  output logic             MOV,
  output logic             ALU2Rd,
  output logic             LHI,
  output logic             LLI,
  output logic             MemoryW,
  output logic             PCW,
  output logic             WE,
  output logic             S_Rn_or_Rd,
  output logic [15:0]      PC_data,
  output logic [3:0]       flags,
  output logic             busy,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [4:0] OP_ALU  = 5'b00000;
  localparam logic [4:0] OP_ADDI = 5'b00001;
  localparam logic [4:0] OP_SUBI = 5'b00010;
  localparam logic [4:0] OP_MOV  = 5'b00011;
  localparam logic [4:0] OP_LHI  = 5'b00100;
  localparam logic [4:0] OP_LLI  = 5'b00101;
  localparam logic [4:0] OP_LDR  = 5'b00110;
  localparam logic [4:0] OP_STR  = 5'b00111;
  localparam logic [4:0] OP_JAL  = 5'b01000;
  localparam logic [4:0] OP_HLT  = 5'b11111;

  state_t           r_state;
  state_t           w_next;
  logic [15:0]      r_pc;
  logic [15:0]      r_ir;
  logic [3:0]       r_flags;
  logic [CNT_W-1:0] r_ret;
  logic             r_ill;
  logic [15:0]      r_daddr;
  logic [15:0]      r_dwdata;
  logic             r_dwe;

  logic [4:0]  w_op;
  logic        w_alu, w_addi, w_subi, w_mov, w_lhi, w_lli;
  logic        w_ldr, w_str, w_jal, w_hlt, w_bad, w_arith;
  logic        w_act;
  logic        w_retire;
  logic [15:0] w_pc1;
  logic [15:0] w_jtgt;

  assign w_op    = r_ir[15:11];
  assign w_alu   = (w_op == OP_ALU);
  assign w_addi  = (w_op == OP_ADDI);
  assign w_subi  = (w_op == OP_SUBI);
  assign w_mov   = (w_op == OP_MOV);
  assign w_lhi   = (w_op == OP_LHI);
  assign w_lli   = (w_op == OP_LLI);
  assign w_ldr   = (w_op == OP_LDR);
  assign w_str   = (w_op == OP_STR);
  assign w_jal   = (w_op == OP_JAL);
  assign w_hlt   = (w_op == OP_HLT);
  assign w_arith = w_alu | w_addi | w_subi;
  assign w_bad   = ~(w_arith | w_mov | w_lhi | w_lli | w_ldr
                   | w_str | w_jal | w_hlt);

  assign w_pc1  = r_pc + 16'd1;
  assign w_jtgt = w_pc1 + {{8{r_ir[7]}}, r_ir[7:0]};

  assign w_act = (r_state == S_DECODE) || (r_state == S_EXEC)
              || (r_state == S_MEM) || (r_state == S_WB);

  assign w_retire = (r_state == S_WB)
                 || ((r_state == S_MEM) && dmem_ack && r_dwe);

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_state  <= S_IDLE;
      r_pc     <= PC_RESET;
      r_ir     <= '0;
      r_flags  <= '0;
      r_ret    <= '0;
      r_ill    <= 1'b0;
      r_daddr  <= '0;
      r_dwdata <= '0;
      r_dwe    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_FETCH && imem_ack)
        r_ir <= imem_rdata;
      if (r_state == S_DECODE && w_bad)
        r_ill <= 1'b1;
      if (r_state == S_EXEC) begin
        r_daddr  <= Result;
        r_dwdata <= RD2;
        r_dwe    <= w_str;
      end
      if (r_state == S_WB && w_arith)
        r_flags <= {C, V, N, Z};
      if (w_retire) begin
        r_ret <= r_ret + CNT_W'(1);
        r_pc  <= w_jal ? w_jtgt : w_pc1;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (start) w_next = S_FETCH;
      S_FETCH:  if (imem_ack) w_next = S_DECODE;
      S_DECODE: begin
        if (w_hlt || w_bad)      w_next = S_HALT;
        else if (w_ldr || w_str) w_next = S_EXEC;
        else                     w_next = S_WB;
      end
      S_EXEC:   w_next = S_MEM;
      S_MEM: begin
        if (dmem_ack) w_next = r_dwe ? S_FETCH : S_WB;
      end
      S_WB:     w_next = S_FETCH;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_IDLE;
    endcase
  end

  // Decode fields are held from DECODE through WB
  always_comb begin
    imem_req   = (r_state == S_FETCH);
    imem_addr  = (r_state == S_FETCH) ? r_pc : 16'h0000;
    dmem_req   = (r_state == S_MEM);
    dmem_we    = (r_state == S_MEM) & r_dwe;
    dmem_addr  = (r_state == S_MEM) ? r_daddr : 16'h0000;
    dmem_wdata = (r_state == S_MEM) ? r_dwdata : 16'h0000;
    ALUctrl    = 2'b00;
    ALUsrc     = 1'b0;
    RdAddr     = 3'd0;
    RnAddr     = 3'd0;
    RmAddr     = 3'd0;
    imm8       = 8'h00;
    imm5       = 5'h00;
    S_Rn_or_Rd = 1'b0;
    PC_data    = 16'h0000;
    if (w_act) begin
      RdAddr     = r_ir[10:8];
      RnAddr     = r_ir[7:5];
      RmAddr     = r_ir[4:2];
      imm8       = r_ir[7:0];
      imm5       = r_ir[4:0];
      ALUsrc     = w_addi | w_subi | w_ldr | w_str;
      S_Rn_or_Rd = w_str;
      if (w_alu)       ALUctrl = r_ir[1:0];
      else if (w_subi) ALUctrl = 2'b10;
      if (w_jal)       PC_data = w_pc1;
    end
  end

  always_comb begin
    WE      = 1'b0;
    MOV     = 1'b0;
    ALU2Rd  = 1'b0;
    LHI     = 1'b0;
    LLI     = 1'b0;
    MemoryW = 1'b0;
    PCW     = 1'b0;
    if (r_state == S_WB) begin
      WE = 1'b1;
      unique case (1'b1)
        w_arith: ALU2Rd  = 1'b1;
        w_mov:   MOV     = 1'b1;
        w_lhi:   LHI     = 1'b1;
        w_lli:   LLI     = 1'b1;
        w_ldr:   MemoryW = 1'b1;
        w_jal:   PCW     = 1'b1;
        default: WE      = 1'b0;
      endcase
    end
  end

  assign busy    = w_act || (r_state == S_FETCH);
  assign halted  = (r_state == S_HALT);
  assign illegal = r_ill;
  assign flags   = r_flags;
  assign retired = r_ret;

endmodule

// File: tb/tb_rf_alu_seq.sv
// tb_rf_alu_seq: directed cycle-by-cycle check of the sequencer
// against hand-computed control values.
module tb_rf_alu_seq;

  logic        CLK;
  logic        CLR;
  logic        start;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic [15:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic        dmem_ack;
  logic [15:0] Result;
  logic [15:0] RD2;
  logic        C, V, N, Z;
  logic [1:0]  ALUctrl;
  logic        ALUsrc;
  logic [2:0]  RdAddr, RnAddr, RmAddr;
  logic [7:0]  imm8;
  logic [4:0]  imm5;
  logic        MOV, ALU2Rd, LHI, LLI, MemoryW, PCW;
  logic        WE;
  logic        S_Rn_or_Rd;
  logic [15:0] PC_data;
  logic [3:0]  flags;
  logic        busy;
  logic        halted;
  logic        illegal;
  logic [15:0] retired;

  logic [15:0] imem [0:31];
  int n_vec = 0;
  int n_err = 0;

  rf_alu_seq #(.PC_RESET(16'h0000), .CNT_W(16)) dut (
    .CLK(CLK), .CLR(CLR), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .Result(Result), .RD2(RD2),
    .C(C), .V(V), .N(N), .Z(Z),
    .ALUctrl(ALUctrl), .ALUsrc(ALUsrc),
    .RdAddr(RdAddr), .RnAddr(RnAddr), .RmAddr(RmAddr),
    .imm8(imm8), .imm5(imm5),
    .MOV(MOV), .ALU2Rd(ALU2Rd), .LHI(LHI), .LLI(LLI),
    .MemoryW(MemoryW), .PCW(PCW), .WE(WE),
    .S_Rn_or_Rd(S_Rn_or_Rd), .PC_data(PC_data),
    .flags(flags), .busy(busy), .halted(halted),
    .illegal(illegal), .retired(retired)
  );

  // Zero-wait instruction memory
  assign imem_ack   = imem_req;
  assign imem_rdata = imem[imem_addr[4:0]];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) imem[i] = 16'h0000;
    imem[0]  = 16'h0528;
    imem[1]  = 16'h2978;
    imem[2]  = 16'h2112;
    imem[3]  = 16'h3B44;
    imem[4]  = 16'h3444;
    imem[5]  = 16'h400A;
    imem[15] = 16'hF800;
    imem[16] = 16'h47FE;
    CLR = 1'b0; start = 1'b0; dmem_ack = 1'b0;
    Result = 16'h0000; RD2 = 16'h0000;
    C = 1'b0; V = 1'b0; N = 1'b0; Z = 1'b0;
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ireq", 32'(imem_req), 32'd0);
    chk("rst_ret", 32'(retired), 32'd0);
    chk("rst_we", 32'(WE), 32'd0);
    tick(); tick();
    CLR = 1'b1;
    tick();
    chk("idle_busy", 32'(busy), 32'd0);

    // ADD R5,R1,R2
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("add_ireq", 32'(imem_req), 32'd1);
    chk("add_iaddr", 32'(imem_addr), 32'h0000);
    C = 1'b1; V = 1'b0; N = 1'b1; Z = 1'b0;
    tick();
    chk("add_rn", 32'(RnAddr), 32'd1);
    chk("add_rm", 32'(RmAddr), 32'd2);
    chk("add_ctl", 32'(ALUctrl), 32'd0);
    chk("add_dec_we", 32'(WE), 32'd0);
    tick();
    chk("add_we", 32'(WE), 32'd1);
    chk("add_a2r", 32'(ALU2Rd), 32'd1);
    chk("add_rd", 32'(RdAddr), 32'd5);
    chk("add_mov", 32'(MOV), 32'd0);
    tick();
    chk("add_iaddr1", 32'(imem_addr), 32'h0001);
    chk("add_ret", 32'(retired), 32'd1);
    chk("add_flags", 32'(flags), 32'hA);
    chk("add_we_off", 32'(WE), 32'd0);
    C = 1'b0; N = 1'b0;

    // LLI R1,0x78 then LHI R1,0x12
    tick(); tick();
    chk("lli_sel", 32'(LLI), 32'd1);
    chk("lli_imm", 32'(imm8), 32'h78);
    chk("lli_we", 32'(WE), 32'd1);
    tick(); tick(); tick();
    chk("lhi_sel", 32'(LHI), 32'd1);
    chk("lhi_lli", 32'(LLI), 32'd0);
    chk("lhi_imm", 32'(imm8), 32'h12);
    tick();
    chk("lhi_ret", 32'(retired), 32'd3);
    chk("lhi_flags", 32'(flags), 32'hA);

    // STR R3,[R2+4], ack in third MEM cycle
    tick();
    chk("str_src", 32'(ALUsrc), 32'd1);
    chk("str_srd", 32'(S_Rn_or_Rd), 32'd1);
    chk("str_imm5", 32'(imm5), 32'd4);
    Result = 16'h0040; RD2 = 16'hBEEF;
    tick();
    tick();
    Result = 16'h0000; RD2 = 16'h0000;
    chk("str_req1", 32'(dmem_req), 32'd1);
    chk("str_addr", 32'(dmem_addr), 32'h0040);
    chk("str_wdat", 32'(dmem_wdata), 32'hBEEF);
    chk("str_we", 32'(dmem_we), 32'd1);
    chk("str_rfwe", 32'(WE), 32'd0);
    tick();
    chk("str_req2", 32'(dmem_req), 32'd1);
    tick();
    chk("str_req3", 32'(dmem_req), 32'd1);
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    chk("str_done", 32'(dmem_req), 32'd0);
    chk("str_we_off", 32'(WE), 32'd0);
    chk("str_ret", 32'(retired), 32'd4);
    chk("str_iaddr", 32'(imem_addr), 32'h0004);

    // LDR R4,[R2+4], zero-wait
    tick();
    chk("ldr_srd", 32'(S_Rn_or_Rd), 32'd0);
    Result = 16'h0044;
    tick();
    tick();
    Result = 16'h0000;
    chk("ldr_we", 32'(dmem_we), 32'd0);
    chk("ldr_addr", 32'(dmem_addr), 32'h0044);
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    chk("ldr_mw", 32'(MemoryW), 32'd1);
    chk("ldr_rfwe", 32'(WE), 32'd1);
    chk("ldr_rd", 32'(RdAddr), 32'd4);
    tick();
    chk("ldr_we_off", 32'(WE), 32'd0);
    chk("ldr_ret", 32'(retired), 32'd5);

    // JAL R0,+10 from 5, then JAL R7,-2 at 0x10
    tick(); tick(); tick();
    chk("jal0_tgt", 32'(imem_addr), 32'h0010);
    tick();
    chk("jal_pcd_dec", 32'(PC_data), 32'h0011);
    tick();
    chk("jal_pcw", 32'(PCW), 32'd1);
    chk("jal_we", 32'(WE), 32'd1);
    chk("jal_rd", 32'(RdAddr), 32'd7);
    chk("jal_pcd", 32'(PC_data), 32'h0011);
    tick();
    chk("jal_tgt", 32'(imem_addr), 32'h000F);
    chk("jal_ret", 32'(retired), 32'd7);
    chk("jal_pcd_off", 32'(PC_data), 32'h0000);

    // HLT at 0x0F
    tick(); tick();
    chk("hlt_halt", 32'(halted), 32'd1);
    chk("hlt_busy", 32'(busy), 32'd0);
    chk("hlt_ret", 32'(retired), 32'd7);
    chk("hlt_ill", 32'(illegal), 32'd0);
    start = 1'b1;
    tick(); tick();
    start = 1'b0;
    chk("hlt_stay", 32'(halted), 32'd1);
    chk("hlt_ireq", 32'(imem_req), 32'd0);

    // Async reset out of HALT
    #2 CLR = 1'b0;
    #1;
    chk("clr_halt", 32'(halted), 32'd0);
    chk("clr_ret", 32'(retired), 32'd0);
    CLR = 1'b1;

    // Reset mid-MEM with dmem_req high
    imem[0] = 16'h3B44;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rs_iaddr", 32'(imem_addr), 32'h0000);
    tick(); tick(); tick();
    chk("rs_req", 32'(dmem_req), 32'd1);
    #2 CLR = 1'b0;
    #1;
    chk("rs_dreq", 32'(dmem_req), 32'd0);
    chk("rs_busy", 32'(busy), 32'd0);
    chk("rs_we", 32'(WE), 32'd0);
    CLR = 1'b1;

    // Illegal opcode at PC_RESET
    imem[0] = 16'h5000;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ill_iaddr", 32'(imem_addr), 32'h0000);
    tick(); tick();
    chk("ill_halt", 32'(halted), 32'd1);
    chk("ill_flag", 32'(illegal), 32'd1);
    chk("ill_ret", 32'(retired), 32'd0);
    start = 1'b1;
    tick(); tick();
    start = 1'b0;
    chk("ill_stay", 32'(halted), 32'd1);
    chk("ill_sticky", 32'(illegal), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
